// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI transmit arbiter: the arbiter state
// encoding and width helpers for the down-counters.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    GAP
  } arb_state_e;

  // Bits needed to hold a counter that is loaded with max_val (at least 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Serialises one frame in SPI mode 0: a CLK_DIV-cycle setup phase with the
// first bit on mosi, then DATA_W bits of sclk high/low half-periods.
// mosi advances only in the cycle sclk falls. `start` loads a frame,
// `setup_end` pulses in the last setup cycle, `done` pulses in the last
// cycle of the final low half.
// Build option: SPI_LSB_FIRST_EN shifts LSB first (default MSB first).
module spi_frame_shifter
  import spi_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              setup_end,
  output logic              done,
  output logic              sclk,
  output logic              mosi
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int BIT_W = cnt_w(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(1);

  logic              active_q, active_d;
  logic              setup_q, setup_d;
  logic              sclk_q, sclk_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;

  // Phase sequencing: count each half-period down, then flip sclk / advance.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    active_d  = active_q;
    setup_d   = setup_q;
    sclk_d    = sclk_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    setup_end = 1'b0;
    done      = 1'b0;
    if (start) begin
      active_d = 1'b1;
      setup_d  = 1'b1;
      sclk_d   = 1'b0;
      div_d    = DIV_LOAD;
      bit_d    = BIT_LOAD;
      sh_d     = data;
    end else if (active_q) begin
      if (div_q == DIV_LAST) begin
        div_d = DIV_LOAD;
        if (setup_q) begin
          setup_d   = 1'b0;
          sclk_d    = 1'b1;
          setup_end = 1'b1;
        end else if (sclk_q) begin
          // Falling edge: the only place mosi is allowed to move.
          sclk_d = 1'b0;
`ifdef SPI_LSB_FIRST_EN
          sh_d   = sh_q >> 1;
`else
          sh_d   = sh_q << 1;
`endif
          bit_d  = bit_q - BIT_W'(1);
        end else if (bit_q == '0) begin
          // End of the last low half, which doubles as CS hold time.
          active_d = 1'b0;
          div_d    = '0;
          done     = 1'b1;
        end else begin
          sclk_d = 1'b1;
        end
      end else begin
        div_d = div_q - DIV_W'(1);
      end
    end
  end

  // State registers; the shift register is cleared too so mosi idles low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      setup_q  <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      active_q <= active_d;
      setup_q  <= setup_d;
      sclk_q   <= sclk_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
    end
  end

  assign sclk = sclk_q;
`ifdef SPI_LSB_FIRST_EN
  assign mosi = sh_q[0];
`else
  assign mosi = sh_q[DATA_W-1];
`endif

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one transmit-only SPI master between NUM_REQ requesters with
// round-robin arbitration. A granted frame runs to completion, ack pulses
// for one cycle, then all chip selects stay high for CS_GAP cycles.
// Build option: SPI_LSB_FIRST_EN selects LSB-first frames (in the shifter).
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       sclk,
  output logic                       mosi,
  output logic [NUM_REQ-1:0]         cs_n
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = cnt_w(CS_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);
  localparam logic [ID_W-1:0]  RR_RESET = ID_W'(NUM_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              any_req;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  logic              start;
  logic [DATA_W-1:0] start_data;
  logic              setup_end;
  logic              frame_done;

  // Round-robin pick: scan from farthest to nearest after the pointer so the
  // nearest asserted request is the one left in `pick`.
  always_comb begin
    any_req = 1'b0;
    pick    = rr_q;
    cand    = rr_q;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = ID_W'((int'(rr_q) + off) % NUM_REQ);
      if (req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign start_data = req_data[int'(pick)*DATA_W +: DATA_W];

  // Arbiter next-state: grant in IDLE, follow the shifter, then ack and gap.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_d       = rr_q;
    gap_d      = gap_q;
    start      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          start      = 1'b1;
          grant_id_d = pick;
          rr_d       = pick;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (setup_end) state_d = SHIFT;
      end
      SHIFT: begin
        if (frame_done) state_d = DONE;
      end
      DONE: begin
        if (CS_GAP == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q <= GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter registers; reset aborts any frame and points RR before index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_q       <= RR_RESET;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
    end
  end

  // Chip-select decode and ack, straight from the registered state so a
  // reset forces every cs_n high without waiting for a clock.
  always_comb begin
    cs_n = '1;
    ack  = '0;
    if (state_q == SETUP || state_q == SHIFT) cs_n[grant_id_q] = 1'b0;
    if (state_q == DONE)                      ack[grant_id_q]  = 1'b1;
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;

  spi_frame_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data      (start_data),
    .setup_end (setup_end),
    .done      (frame_done),
    .sclk      (sclk),
    .mosi      (mosi)
  );

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter. A timeline model (grant cycle plus
// arithmetic offsets) predicts every output each cycle; directed scenarios
// add literal expectations on grant order, ack timing and bit patterns.
module tb_spi_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 2;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int BIT_T   = 2 * CLK_DIV;
  localparam int T_ACK   = 1 + CLK_DIV + BIT_T * DATA_W;
  localparam int T_FREE  = T_ACK + 1 + CS_GAP;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = {8'hC3, 8'h6E, 8'hB1, 8'hB1};
  logic [NUM_REQ-1:0]        ack;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      sclk;
  logic                      mosi;
  logic [NUM_REQ-1:0]        cs_n;

  always #5 clk = ~clk;

  spi_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs_n     (cs_n)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit                m_active = 1'b0;
  int                m_t0 = 0;
  int                m_gid = 0;
  int                m_rr = NUM_REQ - 1;
  logic [DATA_W-1:0] m_data = '0;

  function automatic logic bit_at(input logic [DATA_W-1:0] d, input int k);
    if (k < 0 || k >= DATA_W) return 1'b0;
`ifdef SPI_LSB_FIRST_EN
    return d[k];
`else
    return d[DATA_W-1-k];
`endif
  endfunction

  // Arbitration decisions at each clock edge, using the request the DUT samples.
  initial begin : model
    int j;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_rr     = NUM_REQ - 1;
        m_gid    = 0;
      end else begin
        if (!m_active || cyc >= m_t0 + T_FREE) begin
          for (int off = 1; off <= NUM_REQ; off++) begin
            j = (m_rr + off) % NUM_REQ;
            if (req[j]) begin
              m_active = 1'b1;
              m_t0     = cyc;
              m_gid    = j;
              m_rr     = j;
              m_data   = req_data[j*DATA_W +: DATA_W];
              break;
            end
          end
        end
        cyc = cyc + 1;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model timeline.
  initial begin : compare
    logic               e_sclk, e_mosi, e_busy;
    logic [NUM_REQ-1:0] e_cs, e_ack;
    int                 d, s;
    forever begin
      @(negedge clk);
      e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_cs = '1; e_ack = '0;
      d = cyc - m_t0;
      if (m_active && d >= 1 && d <= T_ACK + CS_GAP) begin
        e_busy = 1'b1;
        if (d < T_ACK)  e_cs[m_gid]  = 1'b0;
        if (d == T_ACK) e_ack[m_gid] = 1'b1;
        s = d - 1 - CLK_DIV;
        if (d <= CLK_DIV) begin
          e_mosi = bit_at(m_data, 0);
        end else if (s < BIT_T * DATA_W) begin
          if (s % BIT_T < CLK_DIV) begin
            e_sclk = 1'b1;
            e_mosi = bit_at(m_data, s / BIT_T);
          end else begin
            e_mosi = bit_at(m_data, s / BIT_T + 1);
          end
        end
      end
      check("sclk", 32'(sclk), 32'(e_sclk));
      check("mosi", 32'(mosi), 32'(e_mosi));
      check("cs_n", 32'(cs_n), 32'(e_cs));
      check("ack", 32'(ack), 32'(e_ack));
      check("busy", 32'(busy), 32'(e_busy));
      check("grant_id", 32'(grant_id), 32'(m_gid));
    end
  end

  // ---------------- event logs from the DUT ----------------
  int                 g_id_q[$], g_cyc_q[$], a_id_q[$], a_cyc_q[$], f_cyc_q[$];
  logic               bit_q[$];
  logic [NUM_REQ-1:0] cs_first = '1;

  initial begin : monitor
    logic p_busy, p_sclk;
    p_busy = 1'b0;
    p_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !p_busy) begin
        g_id_q.push_back(int'(grant_id));
        g_cyc_q.push_back(cyc - 1);
      end
      if (!busy && p_busy) f_cyc_q.push_back(cyc);
      for (int i = 0; i < NUM_REQ; i++)
        if (ack[i]) begin
          a_id_q.push_back(i);
          a_cyc_q.push_back(cyc);
        end
      if (sclk && !p_sclk) bit_q.push_back(mosi);
      if (cs_first === '1 && cs_n !== '1) cs_first = cs_n;
      p_busy = busy;
      p_sclk = sclk;
    end
  end

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [7:0] packed_bits();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[6:0], (i < bit_q.size()) ? bit_q[i] : 1'b0};
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic to_cycle(input int target);
    while (cyc < target) cycles(1);
  endtask

  task automatic clear_logs();
    g_id_q.delete(); g_cyc_q.delete(); a_id_q.delete(); a_cyc_q.delete();
    f_cyc_q.delete(); bit_q.delete(); cs_first = '1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    cycles(3);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name, input int n, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycles(1);
      ok = (g_id_q.size() >= n);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_ack(input string name, input int idx, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycles(1);
      foreach (a_id_q[k]) if (a_id_q[k] == idx) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stimulus
    int g;
    cycles(1);
    check("reset_cs_n", 32'(cs_n), 32'hF);
    check("reset_busy_ack", 32'({busy, ack}), 32'h0);

    // 1: single request from requester 1, data 8'hB1.
    do_reset();
    req = 4'b0010;
    wait_ack("t1_wait_ack", 1, 60);
    req = '0;
    cycles(5);
    check("t1_grant_id", 32'(q_at(g_id_q, 0)), 32'd1);
    check("t1_ack_count", 32'(a_id_q.size()), 32'd1);
    check("t1_ack_latency", 32'(q_at(a_cyc_q, 0) - q_at(g_cyc_q, 0)), 32'd35);
    check("t1_busy_fall", 32'(q_at(f_cyc_q, 0) - q_at(a_cyc_q, 0)), 32'd3);
    check("t1_cs_n", 32'(cs_first), 32'hD);
    check("t1_bit_count", 32'(bit_q.size()), 32'd8);
`ifdef SPI_LSB_FIRST_EN
    check("t1_bits", 32'(packed_bits()), 32'h8D);
`else
    check("t1_bits", 32'(packed_bits()), 32'hB1);
`endif

    // 2: all four requesting continuously.
    do_reset();
    req = 4'b1111;
    wait_grant("t2_wait_grants", 5, 5 * T_FREE + 20);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_order_%0d", k), 32'(q_at(g_id_q, k)), 32'(k % NUM_REQ));
      if (k > 0)
        check($sformatf("t2_spacing_%0d", k), 32'(q_at(g_cyc_q, k) - q_at(g_cyc_q, k - 1)), 32'd38);
    end
    req = '0;
    cycles(T_FREE + 5);

    // 3: requester 2 drops req five cycles into SHIFT; frame still completes.
    do_reset();
    req = 4'b0100;
    wait_grant("t3_wait_grant", 1, 20);
    g = q_at(g_cyc_q, 0);
    req = 4'b0101;
    to_cycle(g + 1 + CLK_DIV + 5);
    req = 4'b0001;
    wait_ack("t3_wait_ack2", 2, 60);
    wait_grant("t3_wait_next", 2, 20);
    check("t3_first_grant", 32'(q_at(g_id_q, 0)), 32'd2);
    check("t3_next_grant", 32'(q_at(g_id_q, 1)), 32'd0);
    req = '0;
    cycles(T_FREE + 5);

    // 4: reset during bit 4 of a frame to requester 2.
    do_reset();
    req = 4'b0100;
    wait_grant("t4_wait_grant", 1, 20);
    g = q_at(g_cyc_q, 0);
    to_cycle(g + 1 + CLK_DIV + 4 * BIT_T + 1);
    check("t4_pre_sclk", 32'(sclk), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_sclk", 32'(sclk), 32'd0);
    check("t4_cs_n", 32'(cs_n), 32'hF);
    check("t4_ack", 32'(ack), 32'h0);
    clear_logs();
    req = 4'b1110;
    cycles(3);
    check("t4_no_ack", 32'(a_id_q.size()), 32'd0);
    rst_n = 1'b1;
    wait_grant("t4_wait_regrant", 1, 20);
    check("t4_regrant", 32'(q_at(g_id_q, 0)), 32'd1);
    req = '0;
    cycles(T_FREE + 5);

    // 5: requester 0 with 8'hB1; data changed after grant must not matter.
    do_reset();
    req_data[7:0] = 8'hB1;
    req = 4'b0001;
    wait_grant("t5_wait_grant", 1, 20);
    req_data[7:0] = 8'h00;
    wait_ack("t5_wait_ack", 0, 60);
    req = '0;
    cycles(5);
`ifdef SPI_LSB_FIRST_EN
    check("t5_bits", 32'(packed_bits()), 32'h8D);
`else
    check("t5_bits", 32'(packed_bits()), 32'hB1);
`endif
    req_data[7:0] = 8'hB1;

    // 6: req[3] rises in the ack[0] cycle while req[0] stays high.
    do_reset();
    req = 4'b0001;
    wait_grant("t6_wait_grant", 1, 20);
    g = q_at(g_cyc_q, 0);
    to_cycle(g + T_ACK);
    check("t6_ack_now", 32'(ack), 32'h1);
    req = 4'b1001;
    wait_grant("t6_wait_next", 2, T_FREE + 10);
    check("t6_next_grant", 32'(q_at(g_id_q, 1)), 32'd3);
    req = '0;
    cycles(T_FREE + 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares one SPI transmit-only master between NUM_REQ requesters.
- Each requester has a dedicated chip select.
- Round-robin arbitration; the whole DATA_W-bit frame is granted atomically; completion is reported with a one-cycle ack.
- Sits between the requesting blocks and the SPI pins (sclk, mosi, cs_n).

Parameters:
- NUM_REQ, 4, number of requesters and chip selects (≥2).
- DATA_W, 8, bits per frame (≥1).
- CLK_DIV, 2, clk cycles per SCLK half-period (≥1).
- CS_GAP, 2, clk cycles with all cs_n high after ack before the next arbitration (≥0).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transfer request, level.
- req_data  in  NUM_REQ*DATA_W  frame for requester i at bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle pulse when requester i's frame is complete.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- sclk  out  1  SPI clock, mode 0 (idle low).
- mosi  out  1  serial data.
- cs_n  out  NUM_REQ  active-low chip selects; at most one low at any time.

Behaviour:
- Reset values: sclk=0, mosi=0, cs_n=all 1, ack=0, busy=0, grant_id=0, state IDLE, RR pointer=NUM_REQ-1 (requester 0 has priority first).
- Reset asserted mid-frame aborts immediately: no ack is issued and cs_n goes high asynchronously.
- States:
  - IDLE: if any req, grant the first asserted index after the RR pointer (wrapping); capture that requester's req_data into the shift register; set grant_id; update the RR pointer to the grant. Next state SETUP. No req: stay in IDLE.
  - SETUP: cs_n[grant] low, mosi=first bit, sclk=0, for CLK_DIV cycles. Then SHIFT.
  - SHIFT: DATA_W bits, each bit is sclk high for CLK_DIV cycles then low for CLK_DIV cycles. mosi changes only in the cycle sclk falls; it never changes while sclk is high. The last bit's low half is the CS hold time. Then DONE.
  - DONE (1 cycle): cs_n all high, ack[grant]=1, mosi=0. Next state GAP, or IDLE if CS_GAP=0.
  - GAP: CS_GAP cycles, all cs_n high. Then IDLE.
- Timing: grant in cycle 0 gives ack in cycle 1+CLK_DIV+2*CLK_DIV*DATA_W. The earliest next grant is DONE+1+CS_GAP.
- Default bit order is MSB first.
- Handshake:
  - A requester holds req high until ack. req_data is sampled only in the grant cycle.
  - Dropping req after grant does not abort: the frame completes and ack still pulses.
  - req held high after ack is a new request and competes fairly in the next IDLE.
  - A request deasserted before being granted is dropped silently.
- Counters: bit counter width $clog2(DATA_W+1); divider counter width $clog2(CLK_DIV+1). Both are reloaded on every state entry; there is no wrap-around beyond the terminal count.

Optional Feature:
- Macro SPI_LSB_FIRST_EN.
- Defined: frames are shifted LSB first (bit 0 in SETUP).
- Undefined: MSB first. No port or timing change in either case.

Decomposition:
- Package spi_arb_pkg: state enum (IDLE, SETUP, SHIFT, DONE, GAP) and the width-helper localparams.
- Sub-module spi_frame_shifter: holds the divider, bit counter, shift register, and sclk/mosi generation. Start/done interface: start pulse plus data in, done pulse out.
- spi_tx_arbiter keeps the arbitration, cs_n decode and ack.

Test Plan:
All cases use defaults (NUM_REQ=4, DATA_W=8, CLK_DIV=2, CS_GAP=2).
1. req=4'b0010, data1=8'hB1:
   - cs_n=4'b1101 for the frame.
   - mosi at the 8 sclk rising edges = 1,0,1,1,0,0,0,1.
   - ack[1] is a single pulse 35 cycles after grant; busy drops after the 2 GAP cycles.
2. req=4'b1111 held continuously: grant order 0,1,2,3,0; consecutive grants are 38 cycles apart; never two cs_n low at once.
3. req[2] deasserted 5 cycles into the SHIFT state: the frame completes, ack[2] still pulses, and the next grant goes to another requester.
4. rst_n pulsed low during bit 4:
   - sclk=0, cs_n=4'hF, no ack.
   - After release, the first grant goes to the lowest asserted index.
5. Built with SPI_LSB_FIRST_EN, data0=8'hB1: mosi at the rising edges = 1,0,0,0,1,1,0,1.
6. req[3] asserted in the same cycle as ack[0], with req[0] still high: the next grant is 3, not 0.
